cyt_rdma_deadlock_report_ctrl: RTL and testbench
================================================

# cyt_rdma_deadlock_report_ctrl

Central collector for the per-instance HLS deadlock monitors in the cyt_rdma kernel (rx/tx pipelines and their loop sub-instances). It arbitrates round-robin among NUM_MON monitor `block` outputs and filters transient stalls by requiring HOLD_CYCLES of continuous assertion. Each confirmed deadlock is reported once, with its index and a timestamp, over a valid/ready report channel. Reported monitors are masked until software clears them.

## Interface
- NUM_MON, 8: number of monitor `block` inputs, 2..32. IDX_W = max(1, clog2(NUM_MON)).
- HOLD_CYCLES, 1024: consecutive asserted cycles required to confirm a deadlock, 2..65535.
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- mon_block  in  NUM_MON  level `block` outputs from the deadlock monitors.
- enable  in  1  level; 0 parks the controller in IDLE.
- clear  in  1  one-cycle pulse; clears reported_mask and deadlock.
- report_valid  out  1  report available.
- report_ready  in  1  consumer accepts the report.
- report_idx  out  IDX_W  index of the confirmed monitor.
- report_time  out  32  value of cycle_cnt at confirmation.
- deadlock  out  1  sticky; set on the first accepted report.
- reported_mask  out  NUM_MON  monitors already reported.
- false_alarms  out  16  saturating count of aborted confirmations.

## Operation
- Reset: FSM=IDLE; rr_ptr=0; cand_idx=0; hold_cnt=0; cycle_cnt=0. All outputs are 0.
- cycle_cnt: free-running 32-bit counter; increments every cycle out of reset and wraps from 2^32-1 to 0.
- eligible = mon_block & ~reported_mask.
- IDLE: if enable=1, go to WATCH.
- WATCH:
  - If enable=0, go to IDLE.
  - Else if eligible≠0: set cand_idx to the first set bit searching upward from rr_ptr, wrapping modulo NUM_MON. Set hold_cnt=1 and go to CONFIRM.
- CONFIRM:
  - If enable=0, go to IDLE with no false-alarm count.
  - Else if mon_block[cand_idx]=0: false_alarms+1 (saturates at 0xFFFF), hold_cnt=0, go to WATCH.
  - Else if hold_cnt=HOLD_CYCLES-1: latch report_idx=cand_idx and report_time=cycle_cnt, go to REPORT.
  - Else hold_cnt+1.
- REPORT:
  - report_valid=1. report_idx and report_time stay stable until the handshake; enable is ignored.
  - On report_valid & report_ready: set reported_mask[cand_idx]=1 and deadlock=1, set rr_ptr=(cand_idx+1) mod NUM_MON, then go to WATCH, or to IDLE if enable=0.
  - A monitor deasserting while in REPORT does not retract the report.
- clear:
  - Sets reported_mask=0 and deadlock=0. false_alarms is not cleared; only reset clears it.
  - In CONFIRM, clear aborts to WATCH with no false-alarm count.
  - In REPORT, clear does not drop report_valid.
  - If clear coincides with a report handshake, clear wins: mask and deadlock end at 0, and rr_ptr still advances.
- All monitors masked: eligible=0, so the FSM stays in WATCH.
- reset mid-REPORT: report_valid drops on the next edge and the report is lost.

## Timing
- Monitor k asserted at cycles t..t+HOLD_CYCLES-1, sampled in WATCH at t → report_valid=1 at cycle t+HOLD_CYCLES.
- report_time equals cycle_cnt sampled at cycle t+HOLD_CYCLES-1.
- After a handshake in cycle h, WATCH is active at h+1. The earliest next report is at h+1+HOLD_CYCLES.
- deadlock and reported_mask update on the edge ending the handshake cycle.
- false_alarms updates one cycle after the deassertion is sampled.
- No combinational path from any input to any output. All outputs are registered.

## Test plan
- Reset and idle:
  - Stimulus: reset, enable=0, mon_block=0xFF for 5000 cycles.
  - Required: every output stays 0; cycle_cnt keeps running.
- Basic confirm (HOLD_CYCLES=16):
  - Stimulus: enable=1, mon_block[3]=1 held; report_ready=0 for 10 cycles, then 1.
  - Required: report_valid rises exactly 16 cycles after first sample with report_idx=3. It holds stable 10 cycles, then handshakes. deadlock=1, reported_mask=0x08, and no further report for index 3.
- Transient stall:
  - Stimulus: mon_block[5] high for 15 cycles, then low.
  - Required: no report; false_alarms=1.
  - Stimulus: repeat 70000 times.
  - Required: false_alarms saturates at 0xFFFF.
- Round-robin:
  - Stimulus: mon_block=0x09 (indices 0 and 3) held.
  - Required: first report idx=0, next report idx=3. After clear, next idx=0, with rr_ptr wrapping from 4.
- Clear/handshake collision:
  - Stimulus: clear pulsed in the handshake cycle.
  - Required: reported_mask=0, deadlock=0, rr_ptr advanced.
- Enable drop and timestamp wrap:
  - Stimulus: enable=0 mid-CONFIRM.
  - Required: IDLE, no false alarm.
  - Stimulus: enable=0 mid-REPORT.
  - Required: report_valid held until the handshake.
  - Stimulus: preload cycle_cnt via force to 0xFFFFFFF0.
  - Required: report_time wraps through 0 correctly.

Source files
------------

// File: rtl/cyt_rdma_deadlock_report_ctrl.sv
// cyt_rdma_deadlock_report_ctrl: round-robin deadlock monitor collector with hold filter and report channel
module cyt_rdma_deadlock_report_ctrl #(
  parameter int NUM_MON = 8,
  parameter int HOLD_CYCLES = 1024,
  localparam int IDX_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               enable,
  input  logic               clear,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [IDX_W-1:0]   report_idx,
  output logic [31:0]        report_time,
  output logic               deadlock,
  output logic [NUM_MON-1:0] reported_mask,
  output logic [15:0]        false_alarms
);
  localparam logic [1:0] IDLE = 2'd0, WATCH = 2'd1, CONFIRM = 2'd2, REPORT = 2'd3;
  logic [1:0]         state;
  logic [IDX_W-1:0]   rr_ptr, cand_idx, pick, j;
  logic [15:0]        hold_cnt;
  logic [31:0]        cycle_cnt;
  logic [NUM_MON-1:0] eligible;
  // scanning downward lets the smallest offset from rr_ptr win
  always_comb begin
    eligible = mon_block & ~reported_mask;
    pick = '0;
    j = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      j = IDX_W'((int'(rr_ptr) + i) % NUM_MON);
      if (eligible[j]) pick = j;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      cand_idx <= '0;
      hold_cnt <= '0;
      cycle_cnt <= '0;
      report_valid <= 1'b0;
      report_idx <= '0;
      report_time <= '0;
      deadlock <= 1'b0;
      reported_mask <= '0;
      false_alarms <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (clear) begin
        reported_mask <= '0;
        deadlock <= 1'b0;
      end
      case (state)
        IDLE: if (enable) state <= WATCH;
        WATCH: begin
          if (!enable) state <= IDLE;
          else if (|eligible) begin
            cand_idx <= pick;
            hold_cnt <= 16'd1;
            state <= CONFIRM;
          end
        end
        CONFIRM: begin
          if (!enable || clear) begin
            hold_cnt <= '0;
            state <= enable ? WATCH : IDLE;
          end else if (!mon_block[cand_idx]) begin
            false_alarms <= false_alarms + {15'd0, false_alarms != 16'hFFFF};
            hold_cnt <= '0;
            state <= WATCH;
          end else if (hold_cnt == 16'(HOLD_CYCLES - 1)) begin
            report_idx <= cand_idx;
            report_time <= cycle_cnt;
            report_valid <= 1'b1;
            state <= REPORT;
          end else hold_cnt <= hold_cnt + 16'd1;
        end
        REPORT: begin
          if (report_ready) begin
            if (!clear) begin
              reported_mask[cand_idx] <= 1'b1;
              deadlock <= 1'b1;
            end
            rr_ptr <= IDX_W'((int'(cand_idx) + 1) % NUM_MON);
            report_valid <= 1'b0;
            state <= enable ? WATCH : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cyt_rdma_deadlock_report_ctrl.sv
// tb_cyt_rdma_deadlock_report_ctrl: directed vector table plus corner sequences, HOLD_CYCLES=16
module tb_cyt_rdma_deadlock_report_ctrl;
  logic clock, reset, enable, clear, report_ready, report_valid, deadlock;
  logic [7:0] mon_block, reported_mask;
  logic [2:0] report_idx;
  logic [31:0] report_time;
  logic [15:0] false_alarms;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic en, clr, rdy;
    logic [7:0] mon;
    int n;
    logic v;
    logic [2:0] idx;
    logic dl;
    logic [7:0] mask;
    logic [15:0] fa;
  } vec_t;
  vec_t tbl[$];

  cyt_rdma_deadlock_report_ctrl #(.NUM_MON(8), .HOLD_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .mon_block(mon_block), .enable(enable), .clear(clear),
    .report_valid(report_valid), .report_ready(report_ready), .report_idx(report_idx),
    .report_time(report_time), .deadlock(deadlock), .reported_mask(reported_mask),
    .false_alarms(false_alarms));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic clr, input logic rdy, input logic [7:0] mon, input int n,
                     input logic v, input logic [2:0] idx, input logic dl, input logic [7:0] mask,
                     input logic [15:0] fa);
    tbl.push_back('{en, clr, rdy, mon, n, v, idx, dl, mask, fa});
  endtask

  task automatic transient(input logic [15:0] exp_fa, input string nm);
    mon_block = 8'h20;
    repeat (15) tick();
    mon_block = 8'h00;
    tick();
    chk(nm, false_alarms, exp_fa);
  endtask

  initial begin
    int bad;
    reset = 1'b1; enable = 1'b0; clear = 1'b0; report_ready = 1'b0; mon_block = 8'h00;
    repeat (3) tick();
    chk("reset valid", report_valid, 0);
    chk("reset deadlock", deadlock, 0);
    chk("reset mask", reported_mask, 0);
    chk("reset fa", false_alarms, 0);
    chk("reset time", report_time, 0);
    reset = 1'b0;
    mon_block = 8'hFF;
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (report_valid || deadlock || reported_mask != 0 || false_alarms != 0 || report_idx != 0 || report_time != 0) bad++;
    end
    chk("idle outputs nonzero cycles", bad, 0);
    chk("idle cycle_cnt", dut.cycle_cnt, 5000);

    //  en clr rdy mon    n  v idx dl mask   fa
    add(1, 0, 0, 8'h00,  2, 0, 0, 0, 8'h00, 0);
    add(1, 0, 0, 8'h08, 15, 0, 0, 0, 8'h00, 0);
    add(1, 0, 0, 8'h08,  1, 1, 3, 0, 8'h00, 0);
    add(1, 0, 0, 8'h08, 10, 1, 3, 0, 8'h00, 0);
    add(1, 0, 1, 8'h08,  1, 0, 3, 1, 8'h08, 0);
    add(1, 0, 1, 8'h08, 40, 0, 3, 1, 8'h08, 0);
    add(1, 0, 0, 8'h20, 15, 0, 3, 1, 8'h08, 0);
    add(1, 0, 0, 8'h00,  1, 0, 3, 1, 8'h08, 1);
    add(1, 1, 0, 8'h00,  1, 0, 3, 0, 8'h00, 1);
    add(1, 0, 0, 8'h00,  1, 0, 3, 0, 8'h00, 1);
    add(1, 0, 0, 8'h09, 16, 1, 0, 0, 8'h00, 1);
    add(1, 0, 1, 8'h09,  1, 0, 0, 1, 8'h01, 1);
    add(1, 0, 0, 8'h09, 16, 1, 3, 1, 8'h01, 1);
    add(1, 1, 1, 8'h09,  1, 0, 3, 0, 8'h00, 1);
    add(1, 0, 0, 8'h09, 16, 1, 0, 0, 8'h00, 1);
    add(1, 0, 1, 8'h09,  1, 0, 0, 1, 8'h01, 1);
    add(1, 0, 0, 8'h08,  5, 0, 0, 1, 8'h01, 1);
    add(0, 0, 0, 8'h08,  1, 0, 0, 1, 8'h01, 1);
    add(0, 0, 0, 8'h08, 20, 0, 0, 1, 8'h01, 1);
    add(1, 0, 0, 8'h08, 17, 1, 3, 1, 8'h01, 1);
    add(0, 0, 0, 8'h00,  5, 1, 3, 1, 8'h01, 1);
    add(0, 1, 0, 8'h00,  1, 1, 3, 0, 8'h00, 1);
    add(0, 0, 1, 8'h00,  1, 0, 3, 1, 8'h08, 1);
    add(0, 0, 0, 8'hFF, 20, 0, 3, 1, 8'h08, 1);
    add(1, 0, 0, 8'h10,  5, 0, 3, 1, 8'h08, 1);
    add(1, 1, 0, 8'h10,  1, 0, 3, 0, 8'h00, 1);
    add(1, 0, 0, 8'h10, 15, 0, 3, 0, 8'h00, 1);
    add(1, 0, 0, 8'h10,  1, 1, 4, 0, 8'h00, 1);
    add(1, 0, 1, 8'h10,  1, 0, 4, 1, 8'h10, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      enable = tbl[i].en; clear = tbl[i].clr; report_ready = tbl[i].rdy; mon_block = tbl[i].mon;
      repeat (tbl[i].n) tick();
      chk($sformatf("row%0d valid", i), report_valid, tbl[i].v);
      if (tbl[i].v) chk($sformatf("row%0d idx", i), report_idx, tbl[i].idx);
      chk($sformatf("row%0d deadlock", i), deadlock, tbl[i].dl);
      chk($sformatf("row%0d mask", i), reported_mask, tbl[i].mask);
      chk($sformatf("row%0d fa", i), false_alarms, tbl[i].fa);
    end

    enable = 1'b1; clear = 1'b0; report_ready = 1'b0; mon_block = 8'h00;
    force dut.false_alarms = 16'hFFFD;
    #1 release dut.false_alarms;
    transient(16'hFFFE, "fa near sat");
    transient(16'hFFFF, "fa reach sat");
    transient(16'hFFFF, "fa stays sat");

    force dut.cycle_cnt = 32'hFFFF_FFF0;
    #1 release dut.cycle_cnt;
    repeat (8) tick();
    mon_block = 8'h40;
    repeat (15) tick();
    chk("wrap early valid", report_valid, 0);
    tick();
    chk("wrap valid", report_valid, 1);
    chk("wrap idx", report_idx, 6);
    chk("wrap time", report_time, 32'h0000_0007);

    reset = 1'b1;
    tick();
    chk("rst mid-report valid", report_valid, 0);
    chk("rst mid-report mask", reported_mask, 0);
    chk("rst mid-report deadlock", deadlock, 0);
    chk("rst mid-report fa", false_alarms, 0);
    reset = 1'b0; enable = 1'b0; report_ready = 1'b1;
    repeat (3) tick();
    chk("post-reset valid", report_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
